exec_trace_capture: RTL and testbench
=====================================

Name: exec_trace_capture

Overview:
- Synthesisable, parametrised execution-trace monitor.
- Attaches to the core's state_out/pc_out/instr_out debug taps inside or beside SOC.
- On each entry into a programmable trigger state, captures {timestamp, PC, INSTR} into an on-chip buffer.
- Buffer drains through a valid/ready port, replacing printf-style simulation monitoring with hardware the FPGA build can keep.

Parameters:
- STATE_W, 3, width of the core state bus.
- DATA_W, 32, width of PC and INSTR.
- TS_W, 32, width of free-running cycle timestamp.
- DEPTH, 16, buffer entries; power of two, minimum 2.
- TRIG_STATE, 3, state value whose entry fires a capture.
- RESET_PREV, 1, value the previous-state register takes at reset.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable; when 0, triggers are ignored.
- mode  in  1  0 = stop-on-full, 1 = overwrite-oldest (ring).
- clear  in  1  synchronous flush of buffer and counters.
- state_in  in  STATE_W  core state tap.
- pc_in  in  DATA_W  core PC tap.
- instr_in  in  DATA_W  core instruction tap.
- rd_valid  out  1  head entry available.
- rd_ready  in  1  consumer accepts head entry.
- rd_ts  out  TS_W  head timestamp.
- rd_pc  out  DATA_W  head PC.
- rd_instr  out  DATA_W  head INSTR.
- count  out  clog2(DEPTH)+1  entries held.
- drop_count  out  16  triggers lost or overwritten; saturates at 16'hFFFF.

Behaviour:
- Reset: all outputs 0; prev_state = RESET_PREV; timestamp = 0; pointers = 0.
- Timestamp increments every cycle and wraps modulo 2^TS_W.
  - clear does not reset the timestamp.
  - RESET does reset it.
- prev_state <= state_in every cycle, independent of enable.
- trig = enable & (state_in == TRIG_STATE) & (prev_state != TRIG_STATE).
  - Holding the trigger state fires once only.
  - Re-entry after leaving fires again.
- push = trig.
  - Entry captured = {timestamp, pc_in, instr_in} sampled in the trig cycle.
  - Entry is visible on rd_* with rd_valid=1 the following cycle (1-cycle latency).
- Read port is show-ahead:
  - rd_* show the head entry whenever rd_valid=1.
  - A pop occurs when rd_valid & rd_ready.
  - The head advances at that edge.
- rd_* are don't-care when rd_valid=0; hold last head value.
- Full, push, no pop, mode 0: entry discarded; drop_count +1.
- Full, push, no pop, mode 1: oldest entry discarded, new entry written; count stays DEPTH; drop_count +1.
- Full, push and pop same cycle: both succeed in either mode; count unchanged; no drop.
- Empty, push and pop same cycle: pop is ignored (rd_valid was 0); count becomes 1.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH.
- clear, cycle n: count, pointers and drop_count are 0 at n+1.
  - A trigger in cycle n is discarded and not counted.
  - prev_state still updates.
- Mid-operation RESET: immediate asynchronous return to reset values; buffer contents are lost.
- mode may change at any time; it takes effect on the next full-buffer push.

Decomposition:
- Package riscy_trace_pkg holds:
  - constants MODE_STOP=0 and MODE_RING=1;
  - the trace-entry packed typedef {ts, pc, instr} sized from parameters;
  - the default TRIG_STATE matching the core's execute state (3).
- Sub-module trace_fifo(DEPTH, WIDTH):
  - show-ahead FIFO with push, pop, overwrite input, count, full and empty;
  - async active-high reset on pointers only.
- exec_trace_capture owns the edge detector, the timestamp, drop_count and the mode logic.

Test Plan:
- Reset, then state sequence 1,2,3,3,1,3 with pc 0x00, 0x04, 0x08, 0x08, 0x0C, 0x10 -> two entries, PC 0x08 then 0x10, with timestamps differing by 3; drop_count 0.
- enable=0 during entry into state 3, then enable=1 while still in state 3 -> no capture until the next re-entry.
- mode 0, DEPTH=16, 20 triggers, rd_ready=0 -> count 16, drop_count 4, head PC = first captured PC.
- mode 1, same stimulus -> count 16, drop_count 4, head = 5th capture, tail = 20th capture.
- Full buffer with trigger and rd_ready=1 in the same cycle -> count stays 16, drop_count unchanged, head advances by one.
- clear asserted with a coincident trigger, then RESET pulsed mid-drain -> count 0, drop_count 0, rd_valid 0; timestamp is 0 after RESET only.

Source files
------------

// File: rtl/riscy_trace_pkg.sv
// Shared constants and the default trace-entry layout for the execution-trace monitor.
package riscy_trace_pkg;

  localparam logic MODE_STOP = 1'b0;
  localparam logic MODE_RING = 1'b1;

  localparam int DEF_STATE_W    = 3;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_TS_W       = 32;
  localparam int DEF_TRIG_STATE = 3;  // core execute state

  typedef struct packed {
    logic [DEF_TS_W-1:0]   ts;
    logic [DEF_DATA_W-1:0] pc;
    logic [DEF_DATA_W-1:0] instr;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO with optional overwrite-oldest on push into a full buffer.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     overwrite,
  input  logic [WIDTH-1:0]         data,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_pop, do_push, ovw;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // overwrite drops the oldest entry by advancing the read pointer alongside the write
  assign ovw     = push & full & ~do_pop & overwrite;
  assign do_push = push & (~full | do_pop | overwrite);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop | ovw) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop | ovw})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push & ~clear) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/exec_trace_capture.sv
// Captures {timestamp, pc, instr} on each entry into the trigger state and drains via valid/ready.
module exec_trace_capture
  import riscy_trace_pkg::*;
#(
  parameter int STATE_W    = DEF_STATE_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TS_W       = DEF_TS_W,
  parameter int DEPTH      = 16,
  parameter int TRIG_STATE = DEF_TRIG_STATE,
  parameter int RESET_PREV = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   enable,
  input  logic                   mode,
  input  logic                   clear,
  input  logic [STATE_W-1:0]     state_in,
  input  logic [DATA_W-1:0]      pc_in,
  input  logic [DATA_W-1:0]      instr_in,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [TS_W-1:0]        rd_ts,
  output logic [DATA_W-1:0]      rd_pc,
  output logic [DATA_W-1:0]      rd_instr,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            drop_count
);
  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  localparam logic [STATE_W-1:0] TRIG = STATE_W'(TRIG_STATE);
  localparam logic [STATE_W-1:0] PREV_INIT = STATE_W'(RESET_PREV);

  logic [TS_W-1:0]    ts;
  logic [STATE_W-1:0] prev_state;
  logic               trig, push, drop, full, empty;
  entry_t             new_entry, head_entry, last_head, shown;

  assign trig      = enable & (state_in == TRIG) & (prev_state != TRIG);
  assign push      = trig & ~clear;
  assign new_entry = '{ts: ts, pc: pc_in, instr: instr_in};
  // a full buffer loses something on push unless a pop frees a slot in the same cycle
  assign drop      = push & full & ~(rd_ready & ~empty);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ts         <= '0;
      prev_state <= PREV_INIT;
    end else begin
      ts         <= ts + 1'b1;
      prev_state <= state_in;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      drop_count <= '0;
    end else if (clear) begin
      drop_count <= '0;
    end else if (drop && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .clear     (clear),
    .push      (push),
    .pop       (rd_ready),
    .overwrite (mode == MODE_RING),
    .data      (new_entry),
    .head      (head_entry),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // keep the last presented head visible once the buffer drains
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_head <= '0;
    end else if (!empty) begin
      last_head <= head_entry;
    end
  end

  assign shown    = empty ? last_head : head_entry;
  assign rd_valid = ~empty;
  assign rd_ts    = shown.ts;
  assign rd_pc    = shown.pc;
  assign rd_instr = shown.instr;

endmodule

// File: tb/tb_exec_trace_capture.sv
// Scoreboard bench for exec_trace_capture: directed triggers queue expected entries, a monitor checks pops.
module tb_exec_trace_capture;
  import riscy_trace_pkg::*;

  localparam logic [31:0] IMASK = 32'hDEAD_0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic        clear = 1'b0;
  logic        rd_ready = 1'b0;
  logic [2:0]  state_in = 3'd0;
  logic [31:0] pc_in = '0;
  logic [31:0] instr_in = '0;
  logic        rd_valid;
  logic [31:0] rd_ts, rd_pc, rd_instr;
  logic [4:0]  count;
  logic [15:0] drop_count;

  int passed = 0;
  int total = 0;
  logic [31:0]  cyc;
  trace_entry_t exp_q[$];
  trace_entry_t mon_e;

  exec_trace_capture #(
    .STATE_W(3), .DATA_W(32), .TS_W(32), .DEPTH(16), .TRIG_STATE(3), .RESET_PREV(1)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .enable     (enable),
    .mode       (mode),
    .clear      (clear),
    .state_in   (state_in),
    .pc_in      (pc_in),
    .instr_in   (instr_in),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_ts      (rd_ts),
    .rd_pc      (rd_pc),
    .rd_instr   (rd_instr),
    .count      (count),
    .drop_count (drop_count)
  );

  always #5 CLK = ~CLK;

  // reference cycle counter: cleared only by RESET
  always @(posedge CLK or posedge RESET) begin
    if (RESET) cyc <= '0;
    else       cyc <= cyc + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
  endtask

  always @(negedge CLK) begin
    if (!RESET && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pop: got pc 0x%0h want no entry", rd_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_ts", rd_ts, mon_e.ts);
        check("pop_pc", rd_pc, mon_e.pc);
        check("pop_instr", rd_instr, mon_e.instr);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [2:0] st, input logic [31:0] pc, input bit capture);
    state_in = st;
    pc_in    = pc;
    instr_in = pc ^ IMASK;
    if (capture) exp_q.push_back('{ts: cyc, pc: pc, instr: pc ^ IMASK});
    tick();
  endtask

  task automatic trig_once(input logic [31:0] pc, input bit capture);
    drive(3'd1, pc, 1'b0);
    drive(3'd3, pc, capture);
  endtask

  task automatic drain(input string name);
    rd_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    rd_ready = 1'b0;
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_count0"}, 32'(count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_pc", rd_pc, 32'd0);
    check("rst_ts", rd_ts, 32'd0);
    RESET = 1'b0;
    enable = 1'b1;

    // state walk 1,2,3,3,1,3: captures at pc 0x08 (ts 2) and 0x10 (ts 5)
    drive(3'd1, 32'h00, 1'b0);
    drive(3'd2, 32'h04, 1'b0);
    drive(3'd3, 32'h08, 1'b1);
    drive(3'd3, 32'h08, 1'b0);
    drive(3'd1, 32'h0C, 1'b0);
    drive(3'd3, 32'h10, 1'b1);
    check("walk_count", 32'(count), 32'd2);
    check("walk_drop", 32'(drop_count), 32'd0);
    check("walk_head_pc", rd_pc, 32'h08);
    check("walk_head_ts", rd_ts, 32'd2);
    drain("walk");

    // entry into state 3 while disabled never fires later
    enable = 1'b0;
    drive(3'd1, 32'h20, 1'b0);
    drive(3'd3, 32'h24, 1'b0);
    enable = 1'b1;
    drive(3'd3, 32'h28, 1'b0);
    drive(3'd3, 32'h2C, 1'b0);
    check("dis_count", 32'(count), 32'd0);
    trig_once(32'h40, 1'b1);
    check("reentry_count", 32'(count), 32'd1);
    drain("reentry");

    // stop-on-full: 20 triggers keep the first 16
    mode = MODE_STOP;
    for (int i = 0; i < 20; i++) trig_once(32'h100 + 32'(4 * i), i < 16);
    check("stop_count", 32'(count), 32'd16);
    check("stop_drop", 32'(drop_count), 32'd4);
    check("stop_head", rd_pc, 32'h100);

    // full buffer: push and pop together, no drop
    drive(3'd1, 32'h300, 1'b0);
    rd_ready = 1'b1;
    drive(3'd3, 32'h300, 1'b1);
    rd_ready = 1'b0;
    check("fullpop_count", 32'(count), 32'd16);
    check("fullpop_drop", 32'(drop_count), 32'd4);
    check("fullpop_head", rd_pc, 32'h104);
    drain("fullpop");

    // ring mode after a clear: head is the 5th capture, tail the 20th
    clear = 1'b1;
    drive(3'd1, 32'h0, 1'b0);
    clear = 1'b0;
    check("clr1_count", 32'(count), 32'd0);
    check("clr1_drop", 32'(drop_count), 32'd0);
    mode = MODE_RING;
    for (int i = 0; i < 20; i++) begin
      if (i >= 16) void'(exp_q.pop_front());
      trig_once(32'h200 + 32'(4 * i), 1'b1);
    end
    check("ring_count", 32'(count), 32'd16);
    check("ring_drop", 32'(drop_count), 32'd4);
    check("ring_head", rd_pc, 32'h210);
    drain("ring");
    check("ring_tail_hold", rd_pc, 32'h24C);
    check("ring_valid0", 32'(rd_valid), 32'd0);

    // clear with a coincident trigger discards it; prev_state still tracks
    mode = MODE_STOP;
    for (int i = 0; i < 3; i++) trig_once(32'h380 + 32'(4 * i), 1'b1);
    drive(3'd1, 32'h3F0, 1'b0);
    clear = 1'b1;
    exp_q.delete();
    drive(3'd3, 32'h3F0, 1'b0);
    clear = 1'b0;
    check("clr2_count", 32'(count), 32'd0);
    check("clr2_drop", 32'(drop_count), 32'd0);
    check("clr2_valid", 32'(rd_valid), 32'd0);
    drive(3'd3, 32'h3F4, 1'b0);
    check("clr2_prev", 32'(count), 32'd0);

    // timestamp keeps running across clear; RESET mid-drain wipes everything
    for (int i = 0; i < 3; i++) trig_once(32'h400 + 32'(4 * i), 1'b1);
    check("post_clr_count", 32'(count), 32'd3);
    rd_ready = 1'b1;
    tick();
    RESET = 1'b1;
    rd_ready = 1'b0;
    exp_q.delete();
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_drop", 32'(drop_count), 32'd0);
    check("arst_valid", 32'(rd_valid), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    state_in = 3'd3;
    pc_in = 32'h500;
    instr_in = 32'h500 ^ IMASK;
    exp_q.push_back('{ts: 32'd0, pc: 32'h500, instr: 32'h500 ^ IMASK});
    tick();
    check("post_rst_count", 32'(count), 32'd1);
    drain("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
